// File: rtl/id_ex_skid_stage.sv
// ID->EX pipeline register: valid/ready handshake, one main and one skid entry,
// synchronous flush and a saturating backpressure counter.
module id_ex_skid_stage #(
   parameter int NUM_SRC = 2,
   parameter int REG_W   = 4,
   parameter int DATA_W  = 16,
   parameter int CNT_W   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_SRC*REG_W-1:0] in_rd,
   input  logic [DATA_W-1:0]        in_imm,
   input  logic [DATA_W-1:0]        in_pc,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_SRC*REG_W-1:0] out_rd,
   output logic [DATA_W-1:0]        out_imm,
   output logic [DATA_W-1:0]        out_pc,
   output logic [CNT_W-1:0]         stall_cnt,
   output logic [1:0]               state_dbg
);

   localparam int RD_W  = NUM_SRC * REG_W;
   localparam int PAY_W = RD_W + 2 * DATA_W;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [PAY_W-1:0]   main_q;
   logic [PAY_W-1:0]   skid_q;
   logic [PAY_W-1:0]   in_pay;
   logic               in_fire;
   logic               out_fire;
   logic               load_main_in;
   logic               load_main_skid;
   logic               load_skid;

   // Handshake: a bundle moves on a cycle where both valid and ready are high.
   // in_ready and out_valid are flops, so neither depends on this cycle's inputs.
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign in_pay    = {in_rd, in_imm, in_pc};
   assign {out_rd, out_imm, out_pc} = main_q;
   assign state_dbg = state;

   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (in_fire) begin
               state_nxt    = ONE;
               load_main_in = 1'b1;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               load_main_in = 1'b1;
            end else if (out_fire) begin
               state_nxt = EMPTY;
            end else if (in_fire) begin
               state_nxt = TWO;
               load_skid = 1'b1;
            end
         end
         TWO: begin
            if (out_fire) begin
               state_nxt      = ONE;
               load_main_skid = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      // Flush squashes everything, including a bundle accepted this cycle.
      if (flush) begin
         state_nxt      = EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= EMPTY;
         main_q    <= '0;
         skid_q    <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         stall_cnt <= '0;
      end else begin
         state     <= state_nxt;
         out_valid <= (state_nxt != EMPTY);
         in_ready  <= (state_nxt != TWO);
         if (load_main_in) begin
            main_q <= in_pay;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (flush) begin
            skid_q <= '0;
         end else if (load_skid) begin
            skid_q <= in_pay;
         end
         if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Bench for id_ex_skid_stage: directed scenarios plus random traffic against a
// two-deep queue model of the stage.
module tb_id_ex_skid_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_rd;
   logic [15:0] in_imm;
   logic [15:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_rd;
   logic [15:0] out_imm;
   logic [15:0] out_pc;
   logic [7:0]  stall_cnt;
   logic [1:0]  state_dbg;

   int checks   = 0;
   int failures = 0;

   logic [39:0] exp_q[$];
   int          stall_m;

   id_ex_skid_stage #(.NUM_SRC(2), .REG_W(4), .DATA_W(16), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_imm(in_imm), .in_pc(in_pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
      .out_imm(out_imm), .out_pc(out_pc), .stall_cnt(stall_cnt),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Queue model: up to two bundles, FIFO order, flush empties it.
   task automatic model_edge();
      logic rdy_m;
      logic vld_m;
      rdy_m = (exp_q.size() < 2);
      vld_m = (exp_q.size() > 0);
      if (vld_m && !out_ready && stall_m < 255) stall_m++;
      if (flush) begin
         exp_q.delete();
      end else begin
         if (vld_m && out_ready) void'(exp_q.pop_front());
         if (in_valid && rdy_m) exp_q.push_back({in_rd, in_imm, in_pc});
      end
   endtask

   task automatic check_outputs();
      check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
      if (exp_q.size() > 0) check("out_payload", 64'({out_rd, out_imm, out_pc}), 64'(exp_q[0]));
   endtask

   task automatic step(input logic v, input logic [39:0] pay, input logic ordy, input logic fl);
      in_valid  = v;
      {in_rd, in_imm, in_pc} = pay;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   function automatic logic [39:0] rnd_pay();
      return {8'($urandom), 32'($urandom)};
   endfunction

   initial begin
      logic [39:0] pa, pb, pc_b;
      // Reset with garbage on the inputs
      reset = 1'b0;
      in_valid = 1'b1; out_ready = 1'b0; flush = 1'b1;
      {in_rd, in_imm, in_pc} = rnd_pay();
      exp_q.delete();
      stall_m = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_payload", 64'({out_rd, out_imm, out_pc}), 64'd0);
      check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      #3 reset = 1'b1;
      in_valid = 1'b0; flush = 1'b0;
      #1;
      check("rel_in_ready", 64'(in_ready), 64'd1);

      // Pass-through, then 8 back-to-back bundles
      pa = {4'h3, 4'hB, 16'h1EEF, 16'h1EC3};
      step(1'b1, pa, 1'b1, 1'b0);
      check("pass_fields", 64'({out_rd, out_imm, out_pc}), 64'(pa));
      for (int i = 0; i < 8; i++) step(1'b1, rnd_pay(), 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);

      // Backpressure: A then B fill both entries
      pa = rnd_pay();
      pb = rnd_pay();
      step(1'b1, pa, 1'b0, 1'b0);
      step(1'b1, pb, 1'b0, 1'b0);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_hold_a", 64'({out_rd, out_imm, out_pc}), 64'(pa));
      for (int i = 0; i < 3; i++) step(1'b1, rnd_pay(), 1'b0, 1'b0);
      check("bp_stall_3", 64'(stall_cnt), 64'd4);
      step(1'b0, '0, 1'b1, 1'b0);
      check("bp_then_b", 64'({out_rd, out_imm, out_pc}), 64'(pb));
      step(1'b0, '0, 1'b1, 1'b0);
      check("bp_drained", 64'(out_valid), 64'd0);

      // Flush while full, with a bundle C offered the same cycle
      step(1'b1, rnd_pay(), 1'b0, 1'b0);
      step(1'b1, rnd_pay(), 1'b0, 1'b0);
      pc_b = rnd_pay();
      step(1'b1, pc_b, 1'b0, 1'b1);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      step(1'b0, '0, 1'b1, 1'b0);
      check("flush_c_dropped", 64'(out_valid), 64'd0);

      // Saturation
      step(1'b1, rnd_pay(), 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) step(1'b0, rnd_pay(), 1'b0, 1'b0);
      check("sat_255", 64'(stall_cnt), 64'd255);
      step(1'b0, '0, 1'b0, 1'b0);
      check("sat_hold", 64'(stall_cnt), 64'd255);

      // Asynchronous reset between edges while stalled
      #2 reset = 1'b0;
      #1;
      check("areset_out_valid", 64'(out_valid), 64'd0);
      check("areset_stall", 64'(stall_cnt), 64'd0);
      check("areset_in_ready", 64'(in_ready), 64'd1);
      exp_q.delete();
      stall_m = 0;
      @(posedge clk);
      #3 reset = 1'b1;
      pa = rnd_pay();
      step(1'b1, pa, 1'b1, 1'b0);
      check("areset_first", 64'({out_rd, out_imm, out_pc}), 64'(pa));
      check("areset_first_v", 64'(out_valid), 64'd1);

      // Random traffic
      for (int i = 0; i < 600; i++)
         step(1'($urandom_range(0, 1)), rnd_pay(), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 15) == 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
